master_out_port: RTL and testbench
==================================

MASTER_OUT_PORT -- requirements
Module: master_out_port

Interface
REQ-001 Parameter ADDR_WIDTH, 12, slave address width and serial address frame length in bits.
REQ-002 Parameter DATA_WIDTH, 8, write-data width and serial data frame length in bits.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  transfer request from master core; sampled only in IDLE.
REQ-006 mode  input  1  1 = write, 0 = read; sampled with start.
REQ-007 address  input  ADDR_WIDTH  target slave address; sampled with start.
REQ-008 wdata  input  DATA_WIDTH  write data; sampled with start; ignored for reads.
REQ-009 slave_ready  input  1  slave can accept a frame.
REQ-010 tx_address  output  1  serial address bit, LSB first.
REQ-011 tx_data  output  1  serial write-data bit, LSB first.
REQ-012 master_valid  output  1  high for every bit cycle of a frame.
REQ-013 write_en  output  1  one-cycle pulse on bit 0 of a write frame.
REQ-014 read_en  output  1  one-cycle pulse on bit 0 of a read frame.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 tx_done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_READY, SEND and DONE; all outputs registered.
REQ-018 IDLE: start=1 at an edge SHALL load address, wdata and mode into shift registers and go to WAIT_READY.
REQ-019 WAIT_READY: slave_ready=1 at an edge SHALL enter SEND, driving bit 0 on the following cycle; slave_ready=0 holds WAIT_READY indefinitely.
REQ-020 SEND SHALL last exactly ADDR_WIDTH cycles, bit counter 0..ADDR_WIDTH-1, one address bit per cycle, master_valid=1.
REQ-021 tx_data SHALL carry wdata bits 0..DATA_WIDTH-1 in the first DATA_WIDTH SEND cycles, then 0; tx_data SHALL be 0 for an entire read frame.
REQ-022 write_en (write) or read_en (read) SHALL be 1 only in SEND cycle 0; never both.
REQ-023 After bit ADDR_WIDTH-1: master_valid=0, DONE for one cycle with tx_done=1, then IDLE.
REQ-024 slave_ready changes during SEND or DONE SHALL be ignored; a frame is never stalled or aborted.
REQ-025 start, address, wdata, mode changes while busy=1 SHALL be ignored; no request queueing.
REQ-026 start held high SHALL launch the next transfer from the first IDLE cycle after DONE (minimum gap one IDLE cycle).
REQ-027 Outside SEND, tx_address, tx_data, master_valid, write_en and read_en SHALL be 0.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, clear counter and shift registers, and drive all outputs 0, including mid-frame.
REQ-029 reset asserted coincident with start SHALL win; no transfer launches.
REQ-030 After reset release, the first start is accepted at the first rising edge with reset=0.

Structure
REQ-031 ADDR_WIDTH/DATA_WIDTH defaults and the FSM state encodings SHALL live in the shared bus package, shared with slave-side ports.
REQ-032 One sub-module, piso_shift_reg (parallel load, LSB-first shift, async reset), SHALL be instantiated twice: address and data.

Verification
REQ-033 Write 0xB35/0x5D, slave_ready=1: tx_address 1,0,1,0,1,1,0,0,1,1,0,1; tx_data 1,0,1,1,1,0,1,0,0,0,0,0; write_en only on bit 0; tx_done one cycle after bit 11.
REQ-034 Read 0xFFF: 12 ones on tx_address, tx_data all 0, read_en pulse on bit 0, write_en never 1.
REQ-035 slave_ready=0 for 5 cycles after start: busy=1, master_valid=0 throughout; frame starts the cycle after slave_ready samples 1.
REQ-036 reset pulse during bit 6: all outputs 0 within the same cycle, busy=0; fresh start afterwards yields a full correct frame.
REQ-037 start pulsed mid-frame with other address: ignored, frame bits unchanged; start held high: back-to-back frames separated by DONE plus one IDLE cycle.

Source files
------------

// File: rtl/master_out_port_pkg.sv
// Shared bus package for the master/slave serial ports.
// Holds the default address/data frame widths and the port FSM state encoding.
package master_out_port_pkg;

    // Address frame length and slave address width, in bits.
    localparam int unsigned ADDR_WIDTH_DEFAULT = 12;
    // Write-data frame length, in bits.
    localparam int unsigned DATA_WIDTH_DEFAULT = 8;

    // StIdle = IDLE, StWaitReady = WAIT_READY, StSend = SEND, StDone = DONE.
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitReady = 2'd1,
        StSend      = 2'd2,
        StDone      = 2'd3
    } port_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears contents)
//   load, din  : parallel load of din (load has priority over shift)
//   shift      : shift one place toward bit 0, filling with 0
//   dout       : current serial bit (bit 0 of the register)
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= din;
        end else if (shift) begin
            // Zero fill: once all loaded bits are out, dout stays 0.
            shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    assign dout = shreg_q[0];

endmodule

// File: rtl/master_out_port.sv
// Master-side serial output port.
// Captures one transfer request in IDLE, waits for the slave to be ready, then
// emits an ADDR_WIDTH-cycle frame carrying the address (and write data on
// tx_data), LSB first, followed by a one-cycle DONE with tx_done.
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   start, mode, address, wdata    : request from the master core (IDLE only)
//   slave_ready                    : slave can accept a frame
//   tx_address, tx_data            : serial address / write-data bits
//   master_valid                   : high for every frame bit cycle
//   write_en, read_en              : pulse on bit 0 of a write / read frame
//   busy, tx_done                  : not in IDLE / pulse after the last bit
// All outputs are registered.
module master_out_port
    import master_out_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  slave_ready,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  master_valid,
    output logic                  write_en,
    output logic                  read_en,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CNT_W = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ADDR_WIDTH - 1);

    port_state_e      state;
    logic [CNT_W-1:0] bit_cnt;
    logic             mode_q;
    logic             sr_load;
    logic             sr_shift;
    logic             addr_bit;
    logic             data_bit;
    logic [DATA_WIDTH-1:0] data_load;

    assign sr_load  = (state == StIdle) && start;
    // Each bit is copied into the output register and shifted out on the same
    // edge, so the register always presents the next bit to send.
    assign sr_shift = ((state == StWaitReady) && slave_ready) ||
                      ((state == StSend) && (bit_cnt != LAST_BIT));
    // Reads load zeros so tx_data stays low for the whole frame.
    assign data_load = mode ? wdata : '0;

    piso_shift_reg #(
        .WIDTH (ADDR_WIDTH)
    ) u_addr_sr (
        .clk   (clk),
        .reset (reset),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (address),
        .dout  (addr_bit)
    );

    piso_shift_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_data_sr (
        .clk   (clk),
        .reset (reset),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (data_load),
        .dout  (data_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            bit_cnt      <= '0;
            mode_q       <= 1'b0;
            tx_address   <= 1'b0;
            tx_data      <= 1'b0;
            master_valid <= 1'b0;
            write_en     <= 1'b0;
            read_en      <= 1'b0;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            write_en <= 1'b0;
            read_en  <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state  <= StWaitReady;
                        mode_q <= mode;
                        busy   <= 1'b1;
                    end
                end
                StWaitReady: begin
                    if (slave_ready) begin
                        state        <= StSend;
                        bit_cnt      <= '0;
                        tx_address   <= addr_bit;
                        tx_data      <= data_bit;
                        master_valid <= 1'b1;
                        write_en     <= mode_q;
                        read_en      <= ~mode_q;
                    end
                end
                StSend: begin
                    if (bit_cnt == LAST_BIT) begin
                        state        <= StDone;
                        bit_cnt      <= '0;
                        tx_address   <= 1'b0;
                        tx_data      <= 1'b0;
                        master_valid <= 1'b0;
                        tx_done      <= 1'b1;
                    end else begin
                        bit_cnt    <= bit_cnt + 1'b1;
                        tx_address <= addr_bit;
                        tx_data    <= data_bit;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_master_out_port.sv
module tb_master_out_port;
    import master_out_port_pkg::*;

    localparam int AW = ADDR_WIDTH_DEFAULT;
    localparam int DW = DATA_WIDTH_DEFAULT;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic          slave_ready;
    logic          tx_address;
    logic          tx_data;
    logic          master_valid;
    logic          write_en;
    logic          read_en;
    logic          busy;
    logic          tx_done;

    int checks   = 0;
    int failures = 0;

    master_out_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .address      (address),
        .wdata        (wdata),
        .slave_ready  (slave_ready),
        .tx_address   (tx_address),
        .tx_data      (tx_data),
        .master_valid (master_valid),
        .write_en     (write_en),
        .read_en      (read_en),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    // {tx_address, tx_data, master_valid, write_en, read_en, busy, tx_done}
    wire [6:0] obs = {tx_address, tx_data, master_valid, write_en, read_en, busy, tx_done};

    // Expected outputs c cycles after the start edge, for a request whose
    // slave_ready arrives d cycles late. Cycles 1..d+1 wait, then AW bits,
    // one DONE cycle, then idle.
    function automatic logic [6:0] model(input logic m, input logic [AW-1:0] a,
                                         input logic [DW-1:0] w, input int d, input int c);
        logic [6:0] v;
        int i;
        v = '0;
        if (c >= 1 && c <= d + 1) begin
            v[1] = 1'b1;
        end else if (c >= d + 2 && c < d + 2 + AW) begin
            i = c - (d + 2);
            v[6] = a[i];
            if (m && i < DW) v[5] = w[i];
            v[4] = 1'b1;
            v[3] = m && (i == 0);
            v[2] = !m && (i == 0);
            v[1] = 1'b1;
        end else if (c == d + 2 + AW) begin
            v[1] = 1'b1;
            v[0] = 1'b1;
        end
        return v;
    endfunction

    // Called at a negedge: present a request for the next edge.
    task automatic launch(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] w,
                          input int d);
        reset       = 1'b0;
        start       = 1'b1;
        mode        = m;
        address     = a;
        wdata       = w;
        slave_ready = (d == 0);
    endtask

    // Called at the negedge after edge c: set inputs for edge c+1.
    task automatic drive_next(input int c, input int d, input bit noise);
        if (c + 1 < d + 2)       slave_ready = 1'b0;
        else if (c + 1 == d + 2) slave_ready = 1'b1;
        else                     slave_ready = noise ? ($urandom % 2 == 1) : 1'b1;
        if (noise && c <= d + 2 + AW) begin
            start   = ($urandom % 2 == 1);
            mode    = ($urandom % 2 == 1);
            address = AW'($urandom);
            wdata   = DW'($urandom);
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        start       = 1'b0;
        mode        = 1'b0;
        address     = '0;
        wdata       = '0;
        slave_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", obs, 7'b0);
        end
        // Reset coincident with start must win.
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL reset_vs_start: got %b expected %b", obs, 7'b0);
        end
    endtask

    task automatic test_write_vector;
        logic [6:0] expv;
        // Released reset together with start: accepted at the first edge.
        launch(1'b1, 12'hB35, 8'h5D, 0);
        for (int c = 1; c <= AW + 3; c++) begin
            @(negedge clk);
            expv = model(1'b1, 12'hB35, 8'h5D, 0, c);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL write_b35 cycle %0d: got %b expected %b", c, obs, expv);
            end
            drive_next(c, 0, 1'b0);
        end
    endtask

    task automatic test_read_ones;
        logic [6:0] expv;
        logic [DW-1:0] w;
        w = DW'($urandom) | 8'h01;
        launch(1'b0, 12'hFFF, w, 0);
        for (int c = 1; c <= AW + 3; c++) begin
            @(negedge clk);
            expv = model(1'b0, 12'hFFF, w, 0, c);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL read_fff cycle %0d: got %b expected %b", c, obs, expv);
            end
            drive_next(c, 0, 1'b0);
        end
    endtask

    task automatic test_ready_stall;
        logic [6:0] expv;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        a = AW'($urandom);
        w = DW'($urandom);
        launch(1'b1, a, w, 5);
        for (int c = 1; c <= 5 + AW + 3; c++) begin
            @(negedge clk);
            expv = model(1'b1, a, w, 5, c);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL ready_stall cycle %0d: got %b expected %b", c, obs, expv);
            end
            drive_next(c, 5, 1'b0);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [6:0] expv;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        a = AW'($urandom);
        w = DW'($urandom);
        launch(1'b1, a, w, 0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            expv = model(1'b1, a, w, 0, c);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL pre_reset cycle %0d: got %b expected %b", c, obs, expv);
            end
            drive_next(c, 0, 1'b0);
        end
        // Now showing bit 6; reset must clear outputs without waiting for an edge.
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL reset_bit6_async: got %b expected %b", obs, 7'b0);
        end
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL reset_bit6_held: got %b expected %b", obs, 7'b0);
        end
        a = AW'($urandom);
        w = DW'($urandom);
        launch(1'b1, a, w, 0);
        for (int c = 1; c <= AW + 3; c++) begin
            @(negedge clk);
            expv = model(1'b1, a, w, 0, c);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL post_reset cycle %0d: got %b expected %b", c, obs, expv);
            end
            drive_next(c, 0, 1'b0);
        end
    endtask

    task automatic test_ignore_start;
        logic [6:0] expv;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        a = AW'($urandom);
        w = DW'($urandom);
        launch(1'b1, a, w, 0);
        for (int c = 1; c <= AW + 3; c++) begin
            @(negedge clk);
            expv = model(1'b1, a, w, 0, c);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL ignore_start cycle %0d: got %b expected %b", c, obs, expv);
            end
            drive_next(c, 0, 1'b0);
            if (c == 6) begin
                start   = 1'b1;
                mode    = 1'b0;
                address = ~a;
                wdata   = ~w;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] expv;
        logic m [3];
        logic [AW-1:0] a [3];
        logic [DW-1:0] w [3];
        for (int f = 0; f < 3; f++) begin
            m[f] = ($urandom % 2 == 1);
            a[f] = AW'($urandom);
            w[f] = DW'($urandom);
        end
        launch(m[0], a[0], w[0], 0);
        for (int f = 0; f < 3; f++) begin
            for (int c = 1; c <= AW + 3; c++) begin
                @(negedge clk);
                expv = model(m[f], a[f], w[f], 0, c);
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL back_to_back frame %0d cycle %0d: got %b expected %b",
                             f, c, obs, expv);
                end
                slave_ready = 1'b1;
                if (c < AW + 3) begin
                    start   = 1'b1;
                    mode    = ($urandom % 2 == 1);
                    address = AW'($urandom);
                    wdata   = DW'($urandom);
                end else if (f < 2) begin
                    start   = 1'b1;
                    mode    = m[f + 1];
                    address = a[f + 1];
                    wdata   = w[f + 1];
                end else begin
                    start = 1'b0;
                end
            end
        end
    endtask

    task automatic test_random;
        logic [6:0] expv;
        logic m;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        int d;
        for (int n = 0; n < 10; n++) begin
            m = ($urandom % 2 == 1);
            a = AW'($urandom);
            w = DW'($urandom);
            d = int'($urandom_range(6, 0));
            launch(m, a, w, d);
            for (int c = 1; c <= d + AW + 3; c++) begin
                @(negedge clk);
                expv = model(m, a, w, d, c);
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL random txn %0d cycle %0d: got %b expected %b",
                             n, c, obs, expv);
                end
                drive_next(c, d, 1'b1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_vector();
        test_read_ones();
        test_ready_stall();
        test_reset_mid_frame();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
